// File: rtl/acc_drain_ctrl_pkg.sv
// Acc_types: shared parameters, types and the diagonal address helper for the
// accumulator drain controller (acc_drain_ctrl) and its output FIFO.
package Acc_types;

  localparam int LANES                = 32;
  localparam int ADDR_W               = 7;
  localparam int DATA_W               = 32;
  localparam int ROW_W                = LANES * DATA_W;
  localparam int ACC_DRAIN_FIFO_DEPTH = 2;

  typedef enum logic {
    ACC_RD_NORMAL = 1'b0,
    ACC_RD_DIAG   = 1'b1
  } acc_rd_mode;

  typedef logic [LANES-1:0][ADDR_W-1:0] diag_addr_array_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } drain_state_t;

  // Lane i reads addr + i, wrapping at 2**ADDR_W; undoes the systolic diagonal skew.
  function automatic diag_addr_array_t diag_addr_LUT(input logic [ADDR_W-1:0] addr);
    diag_addr_array_t lut;
    for (int i = 0; i < LANES; i++) begin
      lut[i] = addr + ADDR_W'(i);
    end
    return lut;
  endfunction

endpackage

// File: rtl/acc_drain_ctrl_fifo.sv
// acc_drain_fifo: small valid/ready row buffer between the accumulator read
// port and the activation stage. Each entry is {last, row payload}. The
// occupancy output feeds the read-credit check in the controller.
module acc_drain_fifo
  import Acc_types::*;
#(
  parameter int WIDTH = ROW_W + 1,
  parameter int DEPTH = ACC_DRAIN_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       not_empty,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign not_empty = (count_q != '0);
  assign do_pop    = pop && not_empty;
  assign do_push   = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
  assign head      = mem_q[rd_ptr_q];
  assign occupancy = count_q;

  // Entry storage, pointers and fill count; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/acc_drain_ctrl.sv
// acc_drain_ctrl: drains result rows from the 32-lane accumulator memory and
// streams them to the activation stage over valid/ready.
// Build option: define ACC_DRAIN_DIAG_EN to enable DIAG (per-lane +i) addressing;
// without it, mode is ignored and every lane reads the same address.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; num_rows=0 answers with done only
//   ST_READ  | issuing one row read per cycle while FIFO credit allows
//   ST_DRAIN | all reads issued; wait for in-flight read and FIFO to empty
module acc_drain_ctrl
  import Acc_types::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  acc_rd_mode        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_rows,
  output logic              acc_rd_en,
  output diag_addr_array_t  acc_rd_addr,
  input  logic [ROW_W-1:0]  acc_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int OCC_W = $clog2(ACC_DRAIN_FIFO_DEPTH + 1);

  drain_state_t      state_q;
  drain_state_t      state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   num_q;
  logic [ADDR_W:0]   row_q;
  logic              in_flight_q;
  logic              in_flight_last_q;
  logic              done_q;

  logic              cmd_accept;
  logic              last_row;
  logic              pop;
  logic              credit_ok;
  logic              drain_empty;
  logic [2:0]        pending;
  logic [ADDR_W-1:0] row_addr;
  diag_addr_array_t  lane_addr;

  logic [ROW_W:0]    fifo_head;
  logic              fifo_not_empty;
  logic [OCC_W-1:0]  fifo_occ;

  assign cmd_accept = (state_q == ST_IDLE) && start;
  assign last_row   = (row_q == num_q - 1'b1);
  assign pop        = fifo_not_empty && out_ready;

  // Rows already owed to the FIFO after this edge must fit in it, so a stalled
  // consumer can never cause a returning read to be dropped.
  assign pending     = 3'(fifo_occ) + 3'(in_flight_q) - 3'(pop);
  assign credit_ok   = (pending < 3'(ACC_DRAIN_FIFO_DEPTH));
  assign drain_empty = !in_flight_q &&
                       ((fifo_occ == '0) || ((fifo_occ == OCC_W'(1)) && pop));

  assign row_addr = base_q + row_q[ADDR_W-1:0];

`ifdef ACC_DRAIN_DIAG_EN
  acc_rd_mode mode_q;

  // Command mode, held for the whole drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= ACC_RD_NORMAL;
    end else if (cmd_accept) begin
      mode_q <= mode;
    end
  end

  // Per-lane skew only when the command asked for DIAG.
  always_comb begin
    lane_addr = {LANES{row_addr}};
    if (mode_q == ACC_RD_DIAG) begin
      lane_addr = diag_addr_LUT(row_addr);
    end
  end
`else
  logic mode_unused;
  assign mode_unused = mode;
  assign lane_addr   = {LANES{row_addr}};
`endif

  assign acc_rd_addr = acc_rd_en ? lane_addr : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and read-strobe decode.
  always_comb begin
    state_d   = state_q;
    acc_rd_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (num_rows != '0)) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (credit_ok) begin
          acc_rd_en = 1'b1;
          if (last_row) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command capture, row counter, read-return tracking and the done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q           <= '0;
      num_q            <= '0;
      row_q            <= '0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      if (cmd_accept) begin
        base_q <= base_addr;
        num_q  <= num_rows;
        row_q  <= '0;
      end else if (acc_rd_en) begin
        row_q <= row_q + 1'b1;
      end
      in_flight_q      <= acc_rd_en;
      in_flight_last_q <= acc_rd_en && last_row;
      done_q           <= (cmd_accept && (num_rows == '0)) || (pop && fifo_head[ROW_W]);
    end
  end

  acc_drain_fifo #(
    .WIDTH (ROW_W + 1),
    .DEPTH (ACC_DRAIN_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_flight_q),
    .push_data ({in_flight_last_q, acc_rd_data}),
    .pop       (pop),
    .head      (fifo_head),
    .not_empty (fifo_not_empty),
    .occupancy (fifo_occ)
  );

  assign out_valid = fifo_not_empty;
  assign out_data  = fifo_head[ROW_W-1:0];
  assign out_last  = fifo_not_empty && fifo_head[ROW_W];

  // The done cycle still counts as busy even though the FSM is back in IDLE.
  assign busy = (state_q != ST_IDLE) || done_q;
  assign done = done_q;

endmodule

// File: tb/tb_acc_drain_ctrl.sv
// Directed bench for acc_drain_ctrl: accumulator memory model, handshake
// monitor and per-command expected addresses/payloads.
module tb_acc_drain_ctrl;
  import Acc_types::*;

`ifdef ACC_DRAIN_DIAG_EN
  localparam bit DIAG_EN = 1'b1;
`else
  localparam bit DIAG_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  acc_rd_mode        mode = ACC_RD_NORMAL;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   num_rows = '0;
  logic              acc_rd_en;
  diag_addr_array_t  acc_rd_addr;
  logic [ROW_W-1:0]  acc_rd_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ROW_W-1:0]  out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_pass   = 0;

  diag_addr_array_t  rd_q[$];
  logic [ROW_W-1:0]  hs_data_q[$];
  logic              hs_last_q[$];
  int                issued = 0;
  int                hs = 0;

  acc_drain_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .base_addr   (base_addr),
    .num_rows    (num_rows),
    .acc_rd_en   (acc_rd_en),
    .acc_rd_addr (acc_rd_addr),
    .acc_rd_data (acc_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a, input int lane);
    return {8'(lane), 9'd0, a, 8'hC3};
  endfunction

  // Accumulator memory: read data appears one cycle after the strobe.
  always @(posedge clk) begin
    if (acc_rd_en) begin
      for (int i = 0; i < LANES; i++) begin
        acc_rd_data[i*DATA_W +: DATA_W] <= mem_word(acc_rd_addr[i], i);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_addr(input string tag, input diag_addr_array_t got, input diag_addr_array_t exp);
    int l;
    l = 0;
    for (int i = LANES - 1; i >= 0; i--) if (got[i] !== exp[i]) l = i;
    check($sformatf("%s lane%0d", tag, l), 64'(got[l]), 64'(exp[l]));
  endtask

  task automatic check_row(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    int l;
    l = 0;
    for (int i = LANES - 1; i >= 0; i--)
      if (got[i*DATA_W +: DATA_W] !== exp[i*DATA_W +: DATA_W]) l = i;
    check($sformatf("%s lane%0d", tag, l), 64'(got[l*DATA_W +: DATA_W]), 64'(exp[l*DATA_W +: DATA_W]));
  endtask

  function automatic diag_addr_array_t exp_addr(input logic [ADDR_W-1:0] b, input int k, input bit diag);
    diag_addr_array_t v;
    for (int i = 0; i < LANES; i++) v[i] = b + ADDR_W'(k) + (diag ? ADDR_W'(i) : ADDR_W'(0));
    return v;
  endfunction

  function automatic logic [ROW_W-1:0] exp_row(input diag_addr_array_t a);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = mem_word(a[i], i);
    return r;
  endfunction

  // Monitor just before each active edge: reads issued, handshakes, stall stability, credit.
  initial begin
    bit               prev_stall;
    logic [ROW_W-1:0] prev_data;
    logic             prev_last;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 64'(out_valid), 64'(1));
          check_row("stall_data", out_data, prev_data);
          check("stall_last", 64'(out_last), 64'(prev_last));
        end
        if (acc_rd_en) begin
          check("credit", 64'((issued - hs - int'(out_valid && out_ready)) < 2), 64'(1));
          rd_q.push_back(acc_rd_addr);
          issued++;
        end
        if (out_valid && out_ready) begin
          hs_data_q.push_back(out_data);
          hs_last_q.push_back(out_last);
          hs++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_rd_en"},  64'(acc_rd_en), 64'(0));
    check({tag, "_rd_addr"}, 64'(acc_rd_addr != '0), 64'(0));
    check({tag, "_valid"},  64'(out_valid), 64'(0));
    check({tag, "_last"},   64'(out_last), 64'(0));
    check({tag, "_data"},   64'(out_data != '0), 64'(0));
    check({tag, "_busy"},   64'(busy), 64'(0));
    check({tag, "_done"},   64'(done), 64'(0));
  endtask

  task automatic spot_addr(input string tag, input int row, input int lane, input logic [ADDR_W-1:0] exp);
    diag_addr_array_t v;
    if (rd_q.size() > row) begin
      v = rd_q[row];
      check(tag, 64'(v[lane]), 64'(exp));
    end else begin
      check({tag, "_missing"}, 64'(rd_q.size()), 64'(row + 1));
    end
  endtask

  // ready_mode 0: out_ready held high; 1: random with a 20-cycle stall.
  task automatic run_cmd(input string name, input acc_rd_mode m, input logic [ADDR_W-1:0] b,
                         input int n, input int ready_mode, input bit poke_busy);
    int  cyc;
    int  first_valid;
    bit  got_done;
    bit  diag;
    diag = DIAG_EN && (m == ACC_RD_DIAG);
    rd_q.delete();
    hs_data_q.delete();
    hs_last_q.delete();
    issued    = 0;
    hs        = 0;
    out_ready = (ready_mode == 0);
    mode      = m;
    base_addr = b;
    num_rows  = 8'(n);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    first_valid = -1;
    got_done = 1'b0;
    check({name, "_busy0"}, 64'(busy), 64'(1));
    if (n > 0) check({name, "_rd_en0"}, 64'(acc_rd_en), 64'(1));
    while (!got_done && cyc < 400) begin
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (ready_mode == 1 && cyc == 20) begin
        check({name, "_rd_silent_full"}, 64'(acc_rd_en), 64'(0));
        check({name, "_held_valid"}, 64'(out_valid), 64'(1));
      end
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (ready_mode == 1) out_ready = (cyc >= 6 && cyc < 26) ? 1'b0 : 1'($urandom_range(0, 1));
        if (poke_busy && cyc == 3) begin
          start = 1'b1;
          num_rows = 8'd7;
          base_addr = 7'd90;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    if (!got_done) begin
      check({name, "_done_timeout"}, 64'(0), 64'(1));
    end else if (ready_mode == 0) begin
      // cyc k is the interval after edge Ek, so the edge that samples it is E(k+1)
      check({name, "_done_edge"}, 64'(cyc + 1), 64'((n == 0) ? 1 : n + 3));
      if (n > 0) check({name, "_first_valid_edge"}, 64'(first_valid + 1), 64'(3));
    end
    @(posedge clk); #1;
    check({name, "_done_pulse"}, 64'(done), 64'(0));
    check({name, "_idle_busy"}, 64'(busy), 64'(0));
    check({name, "_rows_read"}, 64'(rd_q.size()), 64'(n));
    check({name, "_rows_out"}, 64'(hs_data_q.size()), 64'(n));
    for (int k = 0; k < n; k++) begin
      diag_addr_array_t ea;
      ea = exp_addr(b, k, diag);
      if (k < rd_q.size()) check_addr($sformatf("%s_addr%0d", name, k), rd_q[k], ea);
      if (k < hs_data_q.size()) begin
        check_row($sformatf("%s_data%0d", name, k), hs_data_q[k], exp_row(ea));
        check($sformatf("%s_last%0d", name, k), 64'(hs_last_q[k]), 64'(k == n - 1));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_cmd("norm", ACC_RD_NORMAL, 7'd5, 4, 0, 1'b0);
    spot_addr("norm_r3", 3, 0, 7'd8);

    run_cmd("diag0", ACC_RD_DIAG, 7'd0, 2, 0, 1'b0);
    spot_addr("diag0_r0_l31", 0, 31, DIAG_EN ? 7'd31 : 7'd0);
    spot_addr("diag0_r1_l31", 1, 31, DIAG_EN ? 7'd32 : 7'd1);

    run_cmd("diag120", ACC_RD_DIAG, 7'd120, 10, 0, 1'b0);
    spot_addr("diag120_r9_l10", 9, 10, DIAG_EN ? 7'd11 : 7'd1);

    run_cmd("wrap", ACC_RD_NORMAL, 7'd126, 4, 0, 1'b0);
    spot_addr("wrap_r2", 2, 0, 7'd0);
    spot_addr("wrap_r3", 3, 17, 7'd1);

    run_cmd("stall", ACC_RD_NORMAL, 7'd40, 12, 1, 1'b0);

    run_cmd("zero", ACC_RD_NORMAL, 7'd9, 0, 0, 1'b0);

    run_cmd("busy_start", ACC_RD_NORMAL, 7'd10, 5, 0, 1'b1);

    out_ready = 1'b0;
    mode      = ACC_RD_NORMAL;
    base_addr = 7'd3;
    num_rows  = 8'd10;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    reset_checks("mid_rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_cmd("post_rst", ACC_RD_DIAG, 7'd60, 3, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/acc_drain_ctrl.md
# acc_drain_ctrl

Drains result rows out of the 32-lane accumulator memory and streams them to the activation stage with a valid/ready handshake. Generates per-lane read addresses in NORMAL mode (same address on every lane) or DIAG mode (lane i offset by +i, undoing the diagonal skew left by the systolic array). Sits directly downstream of the accumulator memory and upstream of the activation/unified-buffer writeback path.

## Interface
- LANES, 32, accumulator lanes (columns)
- ADDR_W, 7, accumulator address width (128 entries)
- DATA_W, 32, accumulator word width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  command strobe; accepted only in IDLE
- mode  in  acc_rd_mode  NORMAL or DIAG, sampled with start
- base_addr  in  ADDR_W  first logical row address, sampled with start
- num_rows  in  ADDR_W+1  rows to drain, 0..128, sampled with start
- acc_rd_en  out  1  accumulator read strobe
- acc_rd_addr  out  diag_addr_array_t  per-lane read address
- acc_rd_data  in  LANES*DATA_W  read data, valid exactly 1 cycle after acc_rd_en
- out_valid  out  1  row available
- out_ready  in  1  downstream accepts row
- out_data  out  LANES*DATA_W  row payload, lane 0 in LSBs
- out_last  out  1  marks final row of the command
- busy  out  1  command in progress
- done  out  1  one-cycle pulse after the last row handshakes

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: start=1 latches mode, base_addr, num_rows. Row counter r is cleared. num_rows=0 produces a done pulse the next cycle and stays in IDLE. Otherwise the block goes to READ.
- READ: issues a read for row r when credit allows: occupancy + in_flight − pop < 2.
  - NORMAL: acc_rd_addr[i] = (base_addr + r) mod 128.
  - DIAG: acc_rd_addr[i] = (base_addr + r + i) mod 128.
  - Address arithmetic is ADDR_W bits and wraps silently; base 120 with 10 rows wraps to 0..1.
  - After issuing row num_rows−1, the block goes to DRAIN.
- acc_rd_data is written into a 2-entry FIFO the cycle after acc_rd_en. Each entry carries a last flag set for row num_rows−1.
- DRAIN: waits until the FIFO is empty and nothing is in flight, then goes to IDLE. The done pulse is asserted in the cycle after the last handshake.
- Handshake:
  - A row transfers when out_valid && out_ready.
  - out_data, out_last and out_valid stay stable while out_valid && !out_ready.
  - out_valid never drops without a handshake.
- start while busy is ignored. There is no abort.
- rst_n=0 mid-command discards the in-flight read and FIFO contents and returns to IDLE.
- Reset values: acc_rd_en=0, acc_rd_addr all 0, out_valid=0, out_last=0, out_data=0, busy=0, done=0.

## Timing
- busy: high from the cycle after start is accepted through the cycle done is asserted.
- start sampled at edge E0:
  - acc_rd_en high in cycle E0..E1.
  - Data captured into the FIFO at E2.
  - out_valid high from E2..E3, so first row latency is 3 cycles.
- With out_ready held high, the block sustains 1 row/cycle. N rows take N+3 cycles from start to done.
- With out_ready low, at most 2 rows are buffered. acc_rd_en stays 0 until credit frees, so no data is lost.
- done and a new start can coincide: start is accepted in the done cycle if the state is IDLE.

## Configuration
- ACC_DRAIN_DIAG_EN defined: DIAG mode is supported as above.
- ACC_DRAIN_DIAG_EN undefined:
  - mode is ignored and every command behaves as NORMAL.
  - All lanes carry the same address, and the per-lane adder logic is removed.

## Structure
- Package Acc_types holds:
  - acc_rd_mode
  - diag_addr_array_t
  - diag_addr_LUT, completed as out[i] = addr + i mod 128; this block uses it for DIAG addressing
  - localparam ACC_DRAIN_FIFO_DEPTH = 2
- Sub-module acc_drain_fifo: 2-entry valid/ready FIFO of {last, LANES*DATA_W} with an occupancy output for the credit check.

## Test plan
- NORMAL, base 5, num_rows 4, out_ready=1 → rows from addresses 5,6,7,8, out_valid first at E3, out_last on the 4th row, done at cycle 7.
- DIAG, base 0, num_rows 2 → row 0 lane 31 reads address 31, row 1 lane 31 reads address 32; out_data matches the de-skewed memory model.
- DIAG, base 120, num_rows 10 → lane 10 of row 9 reads (120+9+10) mod 128 = 11; wrap in NORMAL: base 126, 4 rows → addresses 126,127,0,1.
- out_ready toggled randomly, plus 20 cycles held low mid-command → exactly num_rows handshakes, payload stable while stalled, acc_rd_en silent while FIFO full.
- num_rows=0 → done one cycle later, no acc_rd_en; start while busy → ignored, row count unchanged.
- rst_n low for 1 cycle mid-command → all outputs at reset values next cycle; a fresh start drains correctly.
